// File: rtl/vga_grab_pkg.sv
// ---------------------------------------------------------------------------
// vga_grab_pkg
// Shared definitions for the VGA frame grabber: capture FSM state encoding,
// Avalon register map, control-register bit positions and default raster
// dimensions.
// ---------------------------------------------------------------------------
package vga_grab_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_SEEK       = 2'd2,
    ST_DONE       = 2'd3
  } grab_state_e;

  // Write register map
  localparam logic [2:0] ADDR_X_HI = 3'd0;
  localparam logic [2:0] ADDR_X_LO = 3'd1;
  localparam logic [2:0] ADDR_Y_HI = 3'd2;
  localparam logic [2:0] ADDR_Y_LO = 3'd3;
  localparam logic [2:0] ADDR_CTRL = 3'd4;

  // Read register map
  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_RED      = 3'd1;
  localparam logic [2:0] ADDR_GREEN    = 3'd2;
  localparam logic [2:0] ADDR_BLUE     = 3'd3;
  localparam logic [2:0] ADDR_FRAMES   = 3'd4;
  localparam logic [2:0] ADDR_WIDTH_HI = 3'd5;
  localparam logic [2:0] ADDR_WIDTH_LO = 3'd6;
  localparam logic [2:0] ADDR_LINES    = 3'd7;

  // Control register bits
  localparam int CTRL_ARM = 0;
  localparam int CTRL_CLR = 1;

  // Default visible raster
  localparam int DEF_HACT = 640;
  localparam int DEF_VACT = 480;

endpackage

// File: rtl/vga_stream_tracker.sv
// ---------------------------------------------------------------------------
// vga_stream_tracker
// Watches the VGA timing signals and rebuilds the pixel position.
//   clk, reset_n      : system clock, async active-low reset
//   i_vga_clk         : pixel clock (sampled; a 0->1 step is one pixel)
//   i_vga_vs          : vertical sync, active low
//   i_vga_blank_n     : high during visible pixels
//   o_pix_en          : one-cycle pixel strobe
//   o_x / o_y         : current pixel column / line
//   o_vs_fall         : start of vertical sync
//   o_line_end        : BLANK_n falling edge (end of a visible line)
//   o_in_active       : delayed BLANK_n, i.e. inside the visible area
// ---------------------------------------------------------------------------
module vga_stream_tracker
  import vga_grab_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_vga_clk,
  input  logic       i_vga_vs,
  input  logic       i_vga_blank_n,
  output logic       o_pix_en,
  output logic [9:0] o_x,
  output logic [8:0] o_y,
  output logic       o_vs_fall,
  output logic       o_line_end,
  output logic       o_in_active
);

  logic       r_clk_q;
  logic       r_vs_q;
  logic       r_blank_q;
  logic [9:0] r_x;
  logic [8:0] r_y;

  // Delayed copies start low so that no edge is reported straight out of reset.
  assign o_pix_en    = i_vga_clk & ~r_clk_q;
  assign o_vs_fall   = r_vs_q & ~i_vga_vs;
  assign o_line_end  = r_blank_q & ~i_vga_blank_n;
  assign o_in_active = r_blank_q;
  assign o_x         = r_x;
  assign o_y         = r_y;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_q   <= 1'b0;
      r_vs_q    <= 1'b0;
      r_blank_q <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
    end else begin
      r_clk_q   <= i_vga_clk;
      r_vs_q    <= i_vga_vs;
      r_blank_q <= i_vga_blank_n;

      // x counts pixels already passed on this line, so it equals the
      // column of the pixel presented on the current strobe.
      if (o_line_end)
        r_x <= '0;
      else if (o_pix_en && i_vga_blank_n)
        r_x <= r_x + 10'd1;

      if (o_vs_fall)
        r_y <= '0;
      else if (o_line_end)
        r_y <= r_y + 9'd1;
    end
  end

endmodule

// File: rtl/vga_frame_grabber.sv
// ---------------------------------------------------------------------------
// vga_frame_grabber
// Avalon-MM peripheral that snoops the VGA pixel stream, captures the RGB
// value of one software-selected pixel and optionally measures line width,
// lines per frame and frame count.
//   clk, reset_n                  : 50 MHz clock, async active-low reset
//   chipselect/write/read/address : Avalon slave control
//   writedata / readdata          : 8-bit data, readdata registered (latency 1)
//   VGA_CLK/HS/VS/BLANK_n/R/G/B   : monitored stream (HS unused)
//   irq                           : high while a capture is done
// Build option: define VGA_GRAB_MEASURE_EN to include the width / line /
// frame measurement registers; otherwise addresses 4-7 read as zero.
// ---------------------------------------------------------------------------
module vga_frame_grabber
  import vga_grab_pkg::*;
#(
  parameter int HACT = DEF_HACT,
  parameter int VACT = DEF_VACT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       chipselect,
  input  logic       write,
  input  logic       read,
  input  logic [2:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic       VGA_CLK,
  input  logic       VGA_HS,
  input  logic       VGA_VS,
  input  logic       VGA_BLANK_n,
  input  logic [7:0] VGA_R,
  input  logic [7:0] VGA_G,
  input  logic [7:0] VGA_B,
  output logic       irq
);

  logic       w_pix_en;
  logic [9:0] w_x;
  logic [8:0] w_y;
  logic       w_vs_fall;
  logic       w_line_end;
  logic       w_in_active;

  vga_stream_tracker u_tracker (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_vga_clk     (VGA_CLK),
    .i_vga_vs      (VGA_VS),
    .i_vga_blank_n (VGA_BLANK_n),
    .o_pix_en      (w_pix_en),
    .o_x           (w_x),
    .o_y           (w_y),
    .o_vs_fall     (w_vs_fall),
    .o_line_end    (w_line_end),
    .o_in_active   (w_in_active)
  );

  grab_state_e r_state;
  logic [9:0]  r_x;          // software-written target column
  logic [8:0]  r_y;          // software-written target line
  logic [9:0]  r_tx;         // target latched at ARM
  logic [8:0]  r_ty;
  logic        r_done;
  logic        r_error;
  logic [7:0]  r_cap_r;
  logic [7:0]  r_cap_g;
  logic [7:0]  r_cap_b;

  logic       w_wr;
  logic       w_rd;
  logic       w_arm;
  logic       w_clr;
  logic       w_tgt_ok;
  logic       w_hit;
  logic       w_armed;
  logic [7:0] w_meas_rd;
  logic [7:0] w_rd_mux;

  assign w_wr     = chipselect & write;
  assign w_rd     = chipselect & read;
  assign w_arm    = w_wr && (address == ADDR_CTRL) && writedata[CTRL_ARM];
  assign w_clr    = w_wr && (address == ADDR_CTRL) && writedata[CTRL_CLR];
  assign w_tgt_ok = (32'(r_x) < 32'(HACT)) && (32'(r_y) < 32'(VACT));
  assign w_hit    = (r_state == ST_SEEK) && w_pix_en && VGA_BLANK_n &&
                    (w_x == r_tx) && (w_y == r_ty);
  assign w_armed  = (r_state == ST_WAIT_FRAME) || (r_state == ST_SEEK);
  assign irq      = r_done;

  // Target coordinate registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_wr) begin
      unique case (address)
        ADDR_X_HI: r_x[9:8] <= writedata[1:0];
        ADDR_X_LO: r_x[7:0] <= writedata;
        ADDR_Y_HI: r_y[8]   <= writedata[0];
        ADDR_Y_LO: r_y[7:0] <= writedata;
        default: ;
      endcase
    end
  end

  // Capture FSM. Statement order sets priority within a cycle:
  // stream events first, then CLR, then ARM (later assignments win).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_tx    <= '0;
      r_ty    <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_cap_r <= '0;
      r_cap_g <= '0;
      r_cap_b <= '0;
    end else begin
      unique case (r_state)
        ST_WAIT_FRAME: begin
          if (w_vs_fall)
            r_state <= ST_SEEK;
        end
        ST_SEEK: begin
          if (w_hit) begin
            r_cap_r <= VGA_R;
            r_cap_g <= VGA_G;
            r_cap_b <= VGA_B;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_vs_fall) begin
            // A whole frame went by without reaching the target.
            r_error <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: ;
      endcase

      if (w_clr) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
        if ((r_state == ST_DONE) || w_hit)
          r_state <= ST_IDLE;
      end

      if (w_arm) begin
        if (w_tgt_ok) begin
          r_tx    <= r_x;
          r_ty    <= r_y;
          r_state <= ST_WAIT_FRAME;
        end else begin
          r_error <= 1'b1;
          r_state <= ST_IDLE;
        end
      end
    end
  end

`ifdef VGA_GRAB_MEASURE_EN
  logic [7:0] r_frame_cnt;
  logic [9:0] r_width;
  logic [7:0] r_line_cnt;

  // Width is refreshed at every line end; the value left standing after
  // vertical blanking starts belongs to the last visible line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt <= '0;
      r_width     <= '0;
      r_line_cnt  <= '0;
    end else begin
      if (w_vs_fall) begin
        r_frame_cnt <= r_frame_cnt + 8'd1;
        r_line_cnt  <= w_y[7:0];
      end
      if (w_line_end)
        r_width <= w_x;
    end
  end

  always_comb begin
    w_meas_rd = '0;
    unique case (address)
      ADDR_FRAMES:   w_meas_rd = r_frame_cnt;
      ADDR_WIDTH_HI: w_meas_rd = {6'd0, r_width[9:8]};
      ADDR_WIDTH_LO: w_meas_rd = r_width[7:0];
      ADDR_LINES:    w_meas_rd = r_line_cnt;
      default:       w_meas_rd = '0;
    endcase
  end

  logic w_unused;
  assign w_unused = VGA_HS;
`else
  assign w_meas_rd = '0;

  logic w_unused;
  assign w_unused = VGA_HS ^ w_line_end;
`endif

  always_comb begin
    w_rd_mux = '0;
    unique case (address)
      ADDR_STATUS: w_rd_mux = {r_done, w_armed, r_error, w_in_active, 4'b0000};
      ADDR_RED:    w_rd_mux = r_cap_r;
      ADDR_GREEN:  w_rd_mux = r_cap_g;
      ADDR_BLUE:   w_rd_mux = r_cap_b;
      default:     w_rd_mux = w_meas_rd;
    endcase
  end

  // readdata only changes on a read, so it holds between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readdata <= '0;
    else if (w_rd)
      readdata <= w_rd_mux;
  end

endmodule

// File: tb/tb_vga_frame_grabber.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_grabber
// Directed bench for vga_frame_grabber. The raster is shrunk to 104 x 40
// visible pixels (108 pixels per line, one sync line and one back-porch line
// per frame, two clk per pixel) so several frames fit in a short run. Each
// visible pixel carries RGB = {x[7:0], y[7:0], 8'h5A}.
// ---------------------------------------------------------------------------
module tb_vga_frame_grabber;

  localparam int W    = 104;
  localparam int L    = 40;
  localparam int HTOT = 108;

`ifdef VGA_GRAB_MEASURE_EN
  localparam bit MEAS = 1'b1;
`else
  localparam bit MEAS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       chipselect;
  logic       write;
  logic       read;
  logic [2:0] address;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_n;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  logic       irq;

  int n_tests = 0;
  int n_fail  = 0;

  vga_frame_grabber #(.HACT(W), .VACT(L)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .chipselect  (chipselect),
    .write       (write),
    .read        (read),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .VGA_CLK     (VGA_CLK),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_n (VGA_BLANK_n),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_tests++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic set_target(input logic [9:0] tx, input logic [8:0] ty);
    wr(3'd0, {6'd0, tx[9:8]});
    wr(3'd1, tx[7:0]);
    wr(3'd2, {7'd0, ty[8]});
    wr(3'd3, ty[7:0]);
  endtask

  task automatic line(input bit act, input bit vs, input int yy);
    for (int p = 0; p < HTOT; p++) begin
      logic on;
      on = act && (p < W);
      @(negedge clk);
      VGA_CLK     = 1'b0;
      VGA_VS      = vs;
      VGA_HS      = !((p == W + 1) || (p == W + 2));
      VGA_BLANK_n = on;
      VGA_R       = on ? 8'(p)  : 8'h00;
      VGA_G       = on ? 8'(yy) : 8'h00;
      VGA_B       = on ? 8'h5A  : 8'h00;
      @(negedge clk);
      VGA_CLK = 1'b1;
    end
  endtask

  // Sync line (VS low), back-porch line, then nact visible lines.
  task automatic frame(input int nact);
    line(1'b0, 1'b0, 0);
    line(1'b0, 1'b1, 0);
    for (int k = 0; k < nact; k++)
      line(1'b1, 1'b1, k);
  endtask

  initial begin
    logic [7:0] d;
    reset_n = 1'b0;
    chipselect = 1'b0; write = 1'b0; read = 1'b0;
    address = 3'd0; writedata = 8'd0;
    VGA_CLK = 1'b0; VGA_HS = 1'b1; VGA_VS = 1'b1; VGA_BLANK_n = 1'b0;
    VGA_R = 8'd0; VGA_G = 8'd0; VGA_B = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_readdata", readdata, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    reset_n = 1'b1;
    rd(3'd0, d); chk("rst_status", d, 8'h00);
    rd(3'd1, d); chk("rst_red", d, 8'h00);

    // Out-of-range targets
    set_target(10'd700, 9'd0);
    wr(3'd4, 8'h01);
    rd(3'd0, d); chk("oor_x700_status", d, 8'h20);
    chk("oor_irq", {7'd0, irq}, 8'h00);
    set_target(10'd104, 9'd0);
    wr(3'd4, 8'h03);
    rd(3'd0, d); chk("oor_x_eq_hact", d, 8'h20);
    set_target(10'd103, 9'd40);
    wr(3'd4, 8'h03);
    rd(3'd0, d); chk("oor_y_eq_vact", d, 8'h20);
    wr(3'd4, 8'h02);
    rd(3'd0, d); chk("clr_error", d, 8'h00);

    // Capture (100,37) and measure three frames
    set_target(10'd100, 9'd37);
    wr(3'd4, 8'h01);
    rd(3'd0, d); chk("arm_status", d, 8'h40);
    frame(L);
    rd(3'd0, d); chk("cap1_status", d, 8'h80);
    chk("cap1_irq", {7'd0, irq}, 8'h01);
    rd(3'd1, d); chk("cap1_red", d, 8'h64);
    rd(3'd2, d); chk("cap1_green", d, 8'h25);
    rd(3'd3, d); chk("cap1_blue", d, 8'h5A);
    frame(L);
    frame(L);
    rd(3'd4, d); chk("meas_frames", d, MEAS ? 8'h03 : 8'h00);
    rd(3'd5, d); chk("meas_width_hi", d, 8'h00);
    rd(3'd6, d); chk("meas_width_lo", d, MEAS ? 8'h68 : 8'h00);
    rd(3'd7, d); chk("meas_lines", d, MEAS ? 8'h28 : 8'h00);
    rd(3'd0, d); chk("done_holds", d, 8'h80);

    // CLR + re-arm on the last visible column
    set_target(10'd103, 9'd1);
    wr(3'd4, 8'h03);
    rd(3'd0, d); chk("rearm_status", d, 8'h40);
    chk("rearm_irq", {7'd0, irq}, 8'h00);
    frame(2);
    rd(3'd0, d); chk("cap2_status", d, 8'h80);
    rd(3'd1, d); chk("cap2_red", d, 8'h67);
    rd(3'd2, d); chk("cap2_green", d, 8'h01);
    rd(3'd3, d); chk("cap2_blue", d, 8'h5A);

    // Truncated frame: target line 39 never arrives
    set_target(10'd103, 9'd39);
    wr(3'd4, 8'h03);
    frame(30);
    rd(3'd0, d); chk("trunc_seeking", d, 8'h40);
    frame(0);
    rd(3'd0, d); chk("trunc_error", d, 8'h20);

    // Reset while seeking
    set_target(10'd50, 9'd10);
    wr(3'd4, 8'h03);
    frame(5);
    rd(3'd0, d); chk("seek_before_rst", d, 8'h40);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_readdata", readdata, 8'h00);
    chk("midrst_irq", {7'd0, irq}, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      chk($sformatf("post_rst_reg%0d", a), d, 8'h00);
    end
    set_target(10'd50, 9'd10);
    wr(3'd4, 8'h01);
    rd(3'd0, d); chk("post_rst_arm", d, 8'h40);
    frame(11);
    rd(3'd0, d); chk("cap3_status", d, 8'h80);
    chk("cap3_irq", {7'd0, irq}, 8'h01);
    rd(3'd1, d); chk("cap3_red", d, 8'h32);
    rd(3'd2, d); chk("cap3_green", d, 8'h0A);
    rd(3'd3, d); chk("cap3_blue", d, 8'h5A);
    rd(3'd4, d); chk("post_rst_frames", d, MEAS ? 8'h01 : 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
